deser_arbiter: RTL
==================

// Module: deser_arbiter
// PURPOSE
//  Round-robin arbiter sharing one 8-bit serial deserializer among NUM_SRC serial sources.
//  Grants the deserializer to one source for a whole frame and muxes that source's data/write onto it.
//  Captures the completed byte, acks the deserializer and delivers the byte downstream tagged with its source id.
//  Aborts stalled frames by pulsing a deserializer reset.
// PARAMETERS
//  NUM_SRC         4   number of serial requesters (2..8)
//  BITS_PER_FRAME  8   bits per frame; must equal the deserializer width
//  TIMEOUT         64  consecutive stall cycles in STREAM or WAIT_RDY before abort
//  IDW (localparam)    $clog2(NUM_SRC)
// PORTS
//  clk_100mhz    in   1        system clock
//  reset         in   1        synchronous, active-high reset
//  req_i         in   NUM_SRC  per-source channel request
//  src_data_i    in   NUM_SRC  per-source serial bit
//  src_write_i   in   NUM_SRC  per-source bit strobe; honoured only while granted
//  grant_o       out  NUM_SRC  one-hot grant, registered
//  busy_o        out  1        1 when state != IDLE
//  des_data_o    out  1        to deserializer data_in
//  des_write_o   out  1        to deserializer write_in
//  des_ack_o     out  1        to deserializer ack_in, 1-cycle pulse
//  des_reset_o   out  1        1-cycle pulse; ORed with reset at the deserializer
//  des_status_i  in   1        deserializer status_out (1 = free)
//  des_ready_i   in   1        deserializer data_ready
//  des_byte_i    in   8        deserializer data_out
//  byte_o        out  8        captured byte
//  byte_src_o    out  IDW      index of the source that sent byte_o
//  byte_valid_o  out  1        downstream valid
//  byte_ack_i    in   1        downstream accept
//  abort_o       out  1        1-cycle pulse on frame abort
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; bit_cnt=0; stall_cnt=0; last_grant=NUM_SRC-1, so source 0 has first priority.
//  IDLE
//   - When des_status_i=1 and req_i!=0: grant the first requester found searching from last_grant+1 with wrap.
//   - grant_o is valid the next cycle; go to STREAM.
//  STREAM
//   - des_data_o = src_data_i[g] and des_write_o = src_write_i[g], combinational through a zero-latency mux.
//   - Each cycle with des_write_o=1: bit_cnt++ and stall_cnt=0. Otherwise stall_cnt++.
//   - On the BITS_PER_FRAME-th write: grant_o is cleared next cycle; go to WAIT_RDY.
//   - Writes from ungranted sources never reach the deserializer.
//   - req_i changes after the grant are ignored; dropping req does not release the channel.
//  WAIT_RDY
//   - On des_ready_i=1: byte_o<=des_byte_i, byte_src_o<=g, byte_valid_o<=1.
//   - In the same cycle, des_ack_o pulses for 1 cycle; go to DELIVER.
//   - stall_cnt increments while waiting.
//  DELIVER
//   - Hold byte_o, byte_src_o and byte_valid_o stable until byte_ack_i=1.
//   - The cycle after the ack: byte_valid_o=0, last_grant=g, go to IDLE.
//   - No new grant is issued while in DELIVER (backpressure).
//  ABORT (entered when stall_cnt reaches TIMEOUT in STREAM or WAIT_RDY)
//   - des_reset_o=1 and abort_o=1 for exactly 1 cycle; grant_o=0; bit_cnt=0.
//   - last_grant=g, so the stalled source loses priority; go to IDLE.
//  General rules
//   - byte_ack_i while byte_valid_o=0 is ignored.
//   - Counter widths cover BITS_PER_FRAME and TIMEOUT without wrap.
//   - A full frame completes in BITS_PER_FRAME cycles plus deserializer latency.
//   - reset mid-operation has the same effect as a power-on reset. No pulse is emitted on
//     des_reset_o or des_ack_o; the deserializer is cleared by the same reset.
// TESTING
//  T1
//   Stimulus: src0 req, then sends 0,1,0,1,0,1,0,1 on 8 consecutive granted cycles.
//   Response: grant_o=0001 one cycle after req; des_write_o high for 8 cycles; byte_o=0x55,
//   byte_src_o=0, byte_valid_o=1; des_ack_o pulses once.
//  T2
//   Stimulus: all four req held continuously, each sends 0xA0+i.
//   Response: grant order 0,1,2,3,0; byte_src_o and byte_o match each source.
//  T3
//   Stimulus: byte_ack_i held low 10 cycles after byte_valid_o rises.
//   Response: byte_o stable and no grant_o during the hold; IDLE the cycle after ack.
//  T4
//   Stimulus: src2 sends 3 bits then stalls 64 cycles; src3 requesting.
//   Response: des_reset_o=1 and abort_o=1 for 1 cycle; grant_o=0; next grant_o=1000.
//  T5
//   Stimulus: reset asserted after 4 bits of a frame.
//   Response: next cycle all outputs 0, busy_o=0; next grant goes to src0.
//  T6
//   Stimulus: src1 toggles src_write_i while src0 is granted.
//   Response: des_write_o follows src0 only; byte_o equals src0's data.

Source files
------------

// File: rtl/deser_arbiter.sv
// Round-robin arbiter that lends one serial deserializer to NUM_SRC sources,
// one whole frame at a time, and forwards each finished byte with its source id.
module deser_arbiter #(
  parameter int NUM_SRC        = 4,
  parameter int BITS_PER_FRAME = 8,
  parameter int TIMEOUT        = 64,
  localparam int IDW           = $clog2(NUM_SRC)
) (
  input  logic               clk_100mhz,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [NUM_SRC-1:0] src_data_i,
  input  logic [NUM_SRC-1:0] src_write_i,
  output logic [NUM_SRC-1:0] grant_o,
  output logic               busy_o,
  output logic               des_data_o,
  output logic               des_write_o,
  output logic               des_ack_o,
  output logic               des_reset_o,
  input  logic               des_status_i,
  input  logic               des_ready_i,
  input  logic [7:0]         des_byte_i,
  output logic [7:0]         byte_o,
  output logic [IDW-1:0]     byte_src_o,
  output logic               byte_valid_o,
  input  logic               byte_ack_i,
  output logic               abort_o
);

  localparam int BCW = $clog2(BITS_PER_FRAME + 1);
  localparam int SCW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STREAM,
    S_WAIT_RDY,
    S_DELIVER,
    S_ABORT
  } state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] g_idx;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] win_idx;
  logic           win_vld;
  logic [BCW-1:0] bit_cnt;
  logic [SCW-1:0] stall_cnt;
  logic           last_bit;
  logic           stall_hit;

  assign last_bit  = (bit_cnt == BCW'(BITS_PER_FRAME - 1));
  assign stall_hit = (stall_cnt == SCW'(TIMEOUT - 1));
  assign busy_o    = (state != S_IDLE);

  // Round-robin pick: scan downwards so the requester closest after last_grant wins.
  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    for (int i = NUM_SRC; i >= 1; i--) begin
      if (req_i[(int'(last_grant) + i) % NUM_SRC]) begin
        win_idx = IDW'((int'(last_grant) + i) % NUM_SRC);
        win_vld = 1'b1;
      end
    end
  end

  // Zero-latency mux: only the granted source reaches the deserializer, and only while streaming.
  always_comb begin
    des_data_o  = 1'b0;
    des_write_o = 1'b0;
    if (state == S_STREAM) begin
      des_data_o  = src_data_i[g_idx];
      des_write_o = src_write_i[g_idx];
    end
  end

  // State register.
  always_ff @(posedge clk_100mhz) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic and single-cycle pulses; pulses are suppressed while reset is held.
  always_comb begin
    state_nxt   = state;
    des_ack_o   = 1'b0;
    des_reset_o = 1'b0;
    abort_o     = 1'b0;
    case (state)
      S_IDLE: begin
        if (des_status_i && win_vld) state_nxt = S_STREAM;
      end
      S_STREAM: begin
        if (des_write_o) begin
          if (last_bit) state_nxt = S_WAIT_RDY;
        end else if (stall_hit) begin
          state_nxt = S_ABORT;
        end
      end
      S_WAIT_RDY: begin
        if (des_ready_i) begin
          des_ack_o = ~reset;
          state_nxt = S_DELIVER;
        end else if (stall_hit) begin
          state_nxt = S_ABORT;
        end
      end
      S_DELIVER: begin
        if (byte_ack_i) state_nxt = S_IDLE;
      end
      S_ABORT: begin
        des_reset_o = ~reset;
        abort_o     = ~reset;
        state_nxt   = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Grant, counters, priority pointer and the captured byte.
  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      grant_o      <= '0;
      g_idx        <= '0;
      last_grant   <= IDW'(NUM_SRC - 1);
      bit_cnt      <= '0;
      stall_cnt    <= '0;
      byte_o       <= '0;
      byte_src_o   <= '0;
      byte_valid_o <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (state_nxt == S_STREAM) begin
            grant_o   <= NUM_SRC'(1) << win_idx;
            g_idx     <= win_idx;
            bit_cnt   <= '0;
            stall_cnt <= '0;
          end
        end
        S_STREAM: begin
          if (des_write_o) begin
            bit_cnt   <= bit_cnt + 1'b1;
            stall_cnt <= '0;
            if (last_bit) grant_o <= '0;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
            if (stall_hit) grant_o <= '0;
          end
        end
        S_WAIT_RDY: begin
          if (des_ready_i) begin
            byte_o       <= des_byte_i;
            byte_src_o   <= g_idx;
            byte_valid_o <= 1'b1;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end
        S_DELIVER: begin
          if (byte_ack_i) begin
            byte_valid_o <= 1'b0;
            last_grant   <= g_idx;
          end
        end
        S_ABORT: begin
          grant_o    <= '0;
          bit_cnt    <= '0;
          stall_cnt  <= '0;
          last_grant <= g_idx;
        end
        default: ;
      endcase
    end
  end

endmodule
